// File: rtl/xor_frame_cksum_pkg.sv
// Shared types for the XOR frame checksum block.
// State encoding used by xor_frame_cksum_ctrl and visible to the datapath.
package xor_frame_cksum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/xor_frame_cksum_ctrl.sv
// Frame sequencing FSM for xor_frame_cksum.
// state    | meaning
// ST_IDLE  | no word of the current frame accepted yet
// ST_ACCUM | at least one word accepted, frame still open
// ST_HOLD  | frame closed, result presented until the consumer takes it
module xor_frame_cksum_ctrl
  import xor_frame_cksum_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_in_valid,
  input  logic   i_in_last,
  input  logic   i_at_limit,
  input  logic   i_out_ready,
  output logic   o_in_ready,
  output logic   o_out_valid,
  output state_t o_state
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_close;

  // a frame closes on its last word or when the word that fills it is accepted
  assign w_close = i_in_last | i_at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_ACCUM: begin
        if (i_in_valid) begin
          w_state_nxt = w_close ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (i_out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    case (r_state)
      ST_IDLE, ST_ACCUM: o_in_ready  = 1'b1;
      ST_HOLD:           o_out_valid = 1'b1;
      default: begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
      end
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/xor_frame_cksum.sv
// XOR checksum and word count over valid/ready framed input, one result per frame.
// Define XOR_FRAME_CKSUM_PARITY_EN to add the out_parity output.
module xor_frame_cksum
  import xor_frame_cksum_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MAX_WORDS = 16,
  localparam int CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CW-1:0]    out_count,
`ifdef XOR_FRAME_CKSUM_PARITY_EN
  output logic             out_parity,
`endif
  output logic             out_err
);

  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic             r_err;

  logic             w_xfer;
  logic             w_hshk;
  logic [CW-1:0]    w_count_nxt;
  logic             w_at_limit;
  state_t           w_state;

  assign w_xfer      = in_valid & in_ready;
  assign w_hshk      = out_valid & out_ready;
  assign w_count_nxt = r_count + CW'(1);
  assign w_at_limit  = (w_count_nxt == CW'(MAX_WORDS));

  xor_frame_cksum_ctrl u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (in_valid),
    .i_in_last   (in_last),
    .i_at_limit  (w_at_limit),
    .i_out_ready (out_ready),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_state     (w_state)
  );

  // transfers and handshakes are mutually exclusive: in_ready is low in HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (w_hshk) begin
      r_acc   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (w_xfer) begin
      r_acc   <= r_acc ^ in_data;
      r_count <= w_count_nxt;
      r_err   <= w_at_limit & ~in_last;
    end
  end

  assign out_sum   = r_acc;
  assign out_count = r_count;
  assign out_err   = r_err;

`ifdef XOR_FRAME_CKSUM_PARITY_EN
  assign out_parity = ^r_acc;
`endif

  logic w_unused;
  assign w_unused = ^w_state;

endmodule

// File: tb/tb_xor_frame_cksum.sv
// Scoreboard bench for xor_frame_cksum (WIDTH=8, MAX_WORDS=4).
// Stimulus pushes expected frame results; the monitor pops them at each result handshake.
module tb_xor_frame_cksum;
  localparam int WIDTH     = 8;
  localparam int MAX_WORDS = 4;
  localparam int CW        = $clog2(MAX_WORDS + 1);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [CW-1:0]    count;
    logic             err;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [CW-1:0]    out_count;
  logic             out_err;
`ifdef XOR_FRAME_CKSUM_PARITY_EN
  logic             out_parity;
`endif

  int   n_vec  = 0;
  int   n_miss = 0;
  res_t sb_q[$];
  bit   rand_en = 1'b0;

  logic [WIDTH-1:0] m_acc;
  int               m_cnt;

  xor_frame_cksum #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
`ifdef XOR_FRAME_CKSUM_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] s, input int c, input logic e);
    res_t r;
    r.sum   = s;
    r.count = CW'(c);
    r.err   = e;
    sb_q.push_back(r);
  endtask

  // offer one word and return #1 after the edge that accepted it
  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          res_t e;
          e = sb_q.pop_front();
          chk("sb_sum",   64'(out_sum),   64'(e.sum));
          chk("sb_count", 64'(out_count), 64'(e.count));
          chk("sb_err",   64'(out_err),   64'(e.err));
`ifdef XOR_FRAME_CKSUM_PARITY_EN
          chk("sb_parity", 64'(out_parity), 64'(^e.sum));
`endif
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (rand_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum",       64'(out_sum),   64'd0);
    chk("rst_count",     64'(out_count), 64'd0);
    chk("rst_err",       64'(out_err),   64'd0);
    rst_n = 1'b1;
    tick();

    // three-word frame
    out_ready = 1'b1;
    push(8'h55, 3, 1'b0);
    send(8'h0F, 1'b0);
    chk("accum_sum",   64'(out_sum),   64'h0F);
    chk("accum_valid", 64'(out_valid), 64'd0);
    send(8'hF0, 1'b0);
    send(8'hAA, 1'b1);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_sum",   64'(out_sum),   64'h55);
    tick();
    chk("post_hshk_valid", 64'(out_valid), 64'd0);
    chk("post_hshk_count", 64'(out_count), 64'd0);

    // single-word frame
    push(8'h3C, 1, 1'b0);
    send(8'h3C, 1'b1);
    chk("single_valid", 64'(out_valid), 64'd1);
    tick();

    // force-close at MAX_WORDS, then a long stall
    out_ready = 1'b0;
    push(8'h00, 4, 1'b1);
    repeat (4) send(8'h01, 1'b0);
    chk("max_valid",    64'(out_valid), 64'd1);
    chk("max_in_ready", 64'(in_ready),  64'd0);
    in_valid = 1'b1; in_data = 8'h01; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_in_ready", 64'(in_ready),  64'd0);
      chk("stall_sum",      64'(out_sum),   64'h00);
      chk("stall_count",    64'(out_count), 64'd4);
      chk("stall_err",      64'(out_err),   64'd1);
    end
    out_ready = 1'b1;
    send(8'h01, 1'b0);
    chk("restart_sum",   64'(out_sum),   64'h01);
    chk("restart_count", 64'(out_count), 64'd1);
    chk("restart_err",   64'(out_err),   64'd0);
    push(8'h03, 2, 1'b0);
    send(8'h02, 1'b1);
    tick();

    // reset mid-frame
    send(8'h05, 1'b0);
    send(8'h06, 1'b0);
    chk("pre_rst_count", 64'(out_count), 64'd2);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid",    64'(out_valid), 64'd0);
    chk("mid_rst_count",    64'(out_count), 64'd0);
    chk("mid_rst_sum",      64'(out_sum),   64'd0);
    chk("mid_rst_in_ready", 64'(in_ready),  64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    push(8'h11, 1, 1'b0);
    send(8'h11, 1'b1);
    tick();

    // random frames with gaps and random consumer back-pressure
    rand_en = 1'b1;
    m_acc = '0;
    m_cnt = 0;
    for (int f = 0; f < 1000; f++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int w = 0; w < len; w++) begin
        logic [WIDTH-1:0] d;
        logic             l;
        int               gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          in_data = WIDTH'($urandom);
          tick();
        end
        d = WIDTH'($urandom);
        l = (w == len - 1);
        send(d, l);
        m_acc = m_acc ^ d;
        m_cnt++;
        if (l || m_cnt == MAX_WORDS) begin
          push(m_acc, m_cnt, !l);
          m_acc = '0;
          m_cnt = 0;
        end
      end
    end
    rand_en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick();
    tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    chk("end_valid",  64'(out_valid),   64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/xor_frame_cksum.md
XOR_FRAME_CKSUM -- requirements
Module: xor_frame_cksum

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits; legal range 1 to 64.
REQ-002 Parameter MAX_WORDS, default 16, maximum words per frame; legal range 2 to 65535.
REQ-003 Localparam CW = $clog2(MAX_WORDS+1), the word-count width.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  an input word is offered.
REQ-007 in_ready  output  1  the block can accept a word.
REQ-008 in_data  input  WIDTH  input word.
REQ-009 in_last  input  1  the offered word closes the frame.
REQ-010 out_valid  output  1  a frame result is held.
REQ-011 out_ready  input  1  the consumer takes the result.
REQ-012 out_sum  output  WIDTH  bitwise XOR of all words in the frame.
REQ-013 out_count  output  CW  number of words in the frame.
REQ-014 out_err  output  1  the frame was force-closed at MAX_WORDS without in_last.

Function
REQ-015 A transfer occurs when in_valid and in_ready are both high on a rising clk edge; a result handshake occurs when out_valid and out_ready are both high.
REQ-016 The block SHALL have exactly three states: IDLE (no word accepted), ACCUM (at least one word accepted, frame open) and HOLD (result valid).
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD; it SHALL be combinational from state only.
REQ-018 On each transfer, the accumulator SHALL become acc ^ in_data and the count SHALL increment by 1.
- IDLE moves to ACCUM on a transfer with in_last=0.
REQ-019 A transfer with in_last=1, in IDLE or ACCUM, SHALL move the block to HOLD on the same edge.
- out_valid=1 the cycle after that edge (latency 1).
- out_sum includes the last word; out_err=0.
REQ-020 A transfer with in_last=0 that makes the count equal MAX_WORDS SHALL move the block to HOLD with out_err=1.
REQ-021 In HOLD, out_sum, out_count and out_err SHALL stay stable until the result handshake.
REQ-022 The result handshake SHALL move the block to IDLE and clear the accumulator and the count.
- No input word is accepted in that cycle.
REQ-023 A single-word frame (in_last=1 in IDLE) SHALL give out_sum=in_data and out_count=1.
REQ-024 Outside HOLD, out_sum and out_count SHALL show the running values, and out_valid SHALL be 0.
REQ-025 Changes to in_data while in_valid is low SHALL NOT affect state.

Reset
REQ-026 rst_n low SHALL, asynchronously, set the state to IDLE, the accumulator to 0, the count to 0, out_valid to 0 and out_err to 0.
- In_ready is then 1.
REQ-027 A reset during ACCUM or HOLD SHALL discard the frame; no partial result is emitted after release.

Configuration
REQ-028 With macro XOR_FRAME_CKSUM_PARITY_EN defined, the block SHALL add output out_parity (1 bit) equal to the XOR-reduction of out_sum, valid whenever out_valid=1.
- Its reset value is 0.
REQ-029 Without XOR_FRAME_CKSUM_PARITY_EN, the out_parity port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package xor_frame_cksum_pkg SHALL hold the three-value state enum type.
REQ-031 The state machine (state register, next-state logic, in_ready, out_valid) SHALL be a sub-module, xor_frame_cksum_ctrl.
REQ-032 The datapath (accumulator, counter, error flag) SHALL remain in xor_frame_cksum.

Verification
REQ-033 WIDTH=8, frame 0x0F, 0xF0, 0xAA (last) with out_ready=1 -> out_sum=0x55, out_count=3, out_err=0; out_valid one cycle after the last transfer.
REQ-034 Single word 0x3C with in_last=1 -> out_sum=0x3C, out_count=1; with the macro defined, out_parity=0.
REQ-035 MAX_WORDS=4, five words 0x01 with no in_last -> HOLD after the 4th word, out_sum=0x00, out_count=4, out_err=1; the 5th word is stalled (in_ready=0) until out_ready.
REQ-036 out_ready held 0 for 5 cycles after a result -> out_sum, out_count and out_err stable, in_ready=0; releasing out_ready -> IDLE the next cycle, and the next frame starts from acc=0.
REQ-037 rst_n pulsed low mid-frame after 2 words -> out_valid=0 and count=0 immediately; a new frame 0x11 (last) gives out_sum=0x11, out_count=1.
REQ-038 Random in_valid and out_ready toggling over 1000 frames -> every out_sum matches a reference XOR model, and no word is lost or duplicated.
